// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one async-FIFO write port among NREQ
// producers in the write clock domain. A winner keeps the port for a burst
// that ends on its 'last' beat or after MAXBURST beats, whichever is first.
// A requester that has just been served gets the lowest priority for the next
// grant. The FIFO full flag stalls the burst without pushing anything.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DSIZE-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAXBURST - 1);
  localparam logic [GW-1:0] RR_INIT   = GW'(NREQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gnt_id_q, gnt_id_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            win_found;
  logic [GW-1:0]   win_id;
  logic            xfer;
  logic [NREQ-1:0] ready_vec;

  // Pick the first valid requester after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [GW-1:0] cand;
      cand = GW'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Next-state logic and per-beat transfer decision for the grant FSM.
  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    xfer       = 1'b0;
    ready_vec  = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_id_d   = win_id;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        ready_vec[gnt_id_q] = ~wfull;
        xfer                = req_valid[gnt_id_q] & ~wfull;
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (req_last[gnt_id_q] || (beat_cnt_q == BEAT_LAST)) begin
            state_d    = IDLE;
            rr_ptr_d   = gnt_id_q;
            beat_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route the granted requester's data to the FIFO write port.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == gnt_id_q) begin
        wdata = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // Strobes are gated by reset so a burst cut short by reset never pushes.
  always_comb begin
    winc      = xfer & wrst_n;
    req_ready = ready_vec & {NREQ{wrst_n}};
  end

  assign gnt_id = gnt_id_q;
  assign busy   = (state_q == BUSY);

  // State registers with synchronous active-low reset.
  always_ff @(posedge wclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!wrst_n) begin
      state_q    <= IDLE;
      gnt_id_q   <= '0;
      rr_ptr_q   <= RR_INIT;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin order, burst cap,
// FIFO back-pressure, requester stall and reset in the middle of a burst.
// Inputs change 1 time unit after the rising edge; outputs are checked one
// unit later, well clear of the next edge.
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [1:0]            gnt_id;
  logic                  busy;

  int n_vec;
  int n_err;

  fifo_wr_arbiter #(
    .NREQ     (NREQ),
    .DSIZE    (DSIZE),
    .MAXBURST (MAXBURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DSIZE-1:0] v);
    req_data[i*DSIZE +: DSIZE] = v;
  endtask

  // Settle, then compare all outputs; wdata only matters on a push.
  task automatic expect_out(input string tag, input logic exp_busy, input logic exp_winc,
                            input logic [NREQ-1:0] exp_ready, input logic [1:0] exp_gnt,
                            input logic [DSIZE-1:0] exp_wdata);
    #1;
    check({tag, ".busy"},  32'(busy),      32'(exp_busy));
    check({tag, ".winc"},  32'(winc),      32'(exp_winc));
    check({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
    check({tag, ".gnt"},   32'(gnt_id),    32'(exp_gnt));
    if (exp_winc) check({tag, ".wdata"}, 32'(wdata), 32'(exp_wdata));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    wrst_n    = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    wfull     = 1'b0;
    for (int i = 0; i < NREQ; i++) set_data(i, 8'hA0 + 8'(i));

    // T1: reset held for two edges with every requester asking.
    for (int c = 0; c < 2; c++) begin
      tick();
      expect_out($sformatf("t1_rst%0d", c), 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
    end

    // T2: single-beat bursts, grants rotate 0,1,2,3,0 with an idle bubble.
    wrst_n = 1'b1;
    expect_out("t2_idle0", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out($sformatf("t2_gnt%0d", k), 1'b1, 1'b1, 4'b0001 << (k % 4),
                 2'(k % 4), 8'hA0 + 8'(k % 4));
      tick();
      expect_out($sformatf("t2_rel%0d", k), 1'b0, 1'b0, 4'b0000, 2'(k % 4), 8'h00);
    end

    // T3: requester 2 alone, no 'last' -> capped at MAXBURST beats.
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    for (int b = 0; b < MAXBURST; b++) begin
      tick();
      set_data(2, 8'h20 + 8'(b));
      expect_out($sformatf("t3_beat%0d", b), 1'b1, 1'b1, 4'b0100, 2'd2, 8'h20 + 8'(b));
    end
    tick();
    expect_out("t3_bubble", 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00);

    // T4: re-grant of 2, then wfull for 3 cycles after the first beat.
    tick();
    set_data(2, 8'h30);
    expect_out("t4_beat0", 1'b1, 1'b1, 4'b0100, 2'd2, 8'h30);
    tick();
    set_data(2, 8'h31);
    wfull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expect_out($sformatf("t4_full%0d", c), 1'b1, 1'b0, 4'b0000, 2'd2, 8'h00);
      if (c < 2) tick();
    end
    tick();
    wfull = 1'b0;
    expect_out("t4_beat1", 1'b1, 1'b1, 4'b0100, 2'd2, 8'h31);
    tick();
    set_data(2, 8'h32);
    expect_out("t4_beat2", 1'b1, 1'b1, 4'b0100, 2'd2, 8'h32);
    tick();
    set_data(2, 8'h33);
    expect_out("t4_beat3", 1'b1, 1'b1, 4'b0100, 2'd2, 8'h33);
    tick();
    expect_out("t4_rel", 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00);

    // T5: requester 0 granted, then drops valid for 2 cycles while 1 asks.
    req_valid = 4'b0001;
    tick();
    set_data(0, 8'h40);
    expect_out("t5_beat0", 1'b1, 1'b1, 4'b0001, 2'd0, 8'h40);
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      expect_out($sformatf("t5_stall%0d", c), 1'b1, 1'b0, 4'b0001, 2'd0, 8'h00);
      if (c < 1) tick();
    end
    tick();
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    set_data(0, 8'h41);
    expect_out("t5_last", 1'b1, 1'b1, 4'b0001, 2'd0, 8'h41);
    tick();
    expect_out("t5_rel", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
    tick();
    set_data(1, 8'h51);
    expect_out("t5_gnt1", 1'b1, 1'b1, 4'b0010, 2'd1, 8'h51);
    tick();
    expect_out("t5_rel1", 1'b0, 1'b0, 4'b0000, 2'd1, 8'h00);

    // T6: requester 2 burst interrupted by reset after two beats.
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    for (int b = 0; b < 2; b++) begin
      tick();
      set_data(2, 8'h60 + 8'(b));
      expect_out($sformatf("t6_beat%0d", b), 1'b1, 1'b1, 4'b0100, 2'd2, 8'h60 + 8'(b));
    end
    tick();
    wrst_n = 1'b0;
    expect_out("t6_rst_gate", 1'b1, 1'b0, 4'b0000, 2'd2, 8'h00);
    tick();
    expect_out("t6_rst_edge", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00);
    wrst_n    = 1'b1;
    req_valid = 4'b0101;
    set_data(0, 8'h70);
    tick();
    expect_out("t6_regrant", 1'b1, 1'b1, 4'b0001, 2'd0, 8'h70);

    req_valid = 4'b0000;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
